// File: rtl/fastpath_update_queue_if.sv
// Allocation, resolve and update/recovery signal bundle for the fastpath predictor update queue.
// master drives allocations and resolves; slave is the queue itself.
interface fastpath_update_queue_if #(
    parameter int DEPTH     = 16,
    parameter int PC_WIDTH  = 64,
    parameter int GHR_WIDTH = 32,
    parameter int IDX_WIDTH = 6,
    parameter int TAG_W     = $clog2(DEPTH)
);
    logic                           alloc_valid;
    logic                           alloc_ready;
    logic [PC_WIDTH-1:0]            alloc_pc;
    logic [GHR_WIDTH-1:0]           alloc_h;
    logic [GHR_WIDTH*IDX_WIDTH-1:0] alloc_v;
    logic                           alloc_pred;
    logic [TAG_W-1:0]               alloc_tag;
    logic                           resolve_valid;
    logic [TAG_W-1:0]               resolve_tag;
    logic                           resolve_taken;
    logic                           upd_valid;
    logic [PC_WIDTH-1:0]            upd_pc;
    logic [GHR_WIDTH-1:0]           upd_h;
    logic [GHR_WIDTH*IDX_WIDTH-1:0] upd_v;
    logic                           upd_pred;
    logic                           upd_outcome;
    logic                           mispredict;
    logic [GHR_WIDTH-1:0]           recover_h;
    logic [TAG_W:0]                 count;
    logic                           err;

    modport master (
        output alloc_valid, alloc_pc, alloc_h, alloc_v, alloc_pred,
        output resolve_valid, resolve_tag, resolve_taken,
        input  alloc_ready, alloc_tag,
        input  upd_valid, upd_pc, upd_h, upd_v, upd_pred, upd_outcome,
        input  mispredict, recover_h, count, err
    );

    modport slave (
        input  alloc_valid, alloc_pc, alloc_h, alloc_v, alloc_pred,
        input  resolve_valid, resolve_tag, resolve_taken,
        output alloc_ready, alloc_tag,
        output upd_valid, upd_pc, upd_h, upd_v, upd_pred, upd_outcome,
        output mispredict, recover_h, count, err
    );
endinterface

// File: rtl/fastpath_update_queue.sv
// In-order replay queue of fastpath prediction metadata; out-of-order resolve, in-order retire 2 cycles after head resolve.
// alloc_ready drops when full or on a mispredicting resolve; FASTPATH_UPQ_CHECK_EN adds sticky err and assertions.
module fastpath_update_queue #(
    parameter int DEPTH     = 16,
    parameter int PC_WIDTH  = 64,
    parameter int GHR_WIDTH = 32,
    parameter int IDX_WIDTH = 6,
    parameter int TAG_W     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fastpath_update_queue_if.slave io
);
    localparam int PW = TAG_W + 1;
    localparam int VW = GHR_WIDTH * IDX_WIDTH;

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_resolved;
    logic [DEPTH-1:0]     r_outcome;
    logic [DEPTH-1:0]     r_pred;
    logic [PC_WIDTH-1:0]  r_pc [DEPTH];
    logic [GHR_WIDTH-1:0] r_h  [DEPTH];
    logic [VW-1:0]        r_v  [DEPTH];

    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;

    logic                 r_upd_valid;
    logic [PC_WIDTH-1:0]  r_upd_pc;
    logic [GHR_WIDTH-1:0] r_upd_h;
    logic [VW-1:0]        r_upd_v;
    logic                 r_upd_pred;
    logic                 r_upd_outcome;
    logic                 r_mispredict;
    logic [GHR_WIDTH-1:0] r_recover_h;

    logic [PW-1:0]        w_count;
    logic [TAG_W-1:0]     w_head_idx;
    logic [TAG_W-1:0]     w_tail_idx;
    logic                 w_res_legal;
    logic                 w_mismatch;
    logic                 w_alloc_ready;
    logic                 w_alloc_fire;
    logic                 w_retire;
    logic [TAG_W-1:0]     w_res_off;
    logic [PW-1:0]        w_res_ptr;
    logic [DEPTH-1:0]     w_flush;

    assign w_head_idx    = r_head[TAG_W-1:0];
    assign w_tail_idx    = r_tail[TAG_W-1:0];
    assign w_count       = r_tail - r_head;
    assign w_res_legal   = io.resolve_valid && r_valid[io.resolve_tag] && !r_resolved[io.resolve_tag];
    assign w_mismatch    = w_res_legal && (io.resolve_taken != r_pred[io.resolve_tag]);
    assign w_alloc_ready = (w_count != PW'(DEPTH)) && !w_mismatch;
    assign w_alloc_fire  = io.alloc_valid && w_alloc_ready;
    assign w_retire      = r_valid[w_head_idx] && r_resolved[w_head_idx];

    // Age is the distance from head; adding it back to head recovers the tag's wrap bit.
    assign w_res_off = io.resolve_tag - w_head_idx;
    assign w_res_ptr = r_head + PW'(w_res_off);

    always_comb begin
        w_flush = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_flush[i] = w_mismatch && ((TAG_W'(i) - w_head_idx) > w_res_off);
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc_fire) begin
            r_pc[w_tail_idx] <= io.alloc_pc;
            r_h[w_tail_idx]  <= io.alloc_h;
            r_v[w_tail_idx]  <= io.alloc_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid       <= '0;
            r_resolved    <= '0;
            r_outcome     <= '0;
            r_pred        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= '0;
            r_upd_h       <= '0;
            r_upd_v       <= '0;
            r_upd_pred    <= 1'b0;
            r_upd_outcome <= 1'b0;
            r_mispredict  <= 1'b0;
            r_recover_h   <= '0;
        end else begin
            r_upd_valid  <= w_retire;
            r_mispredict <= w_mismatch;

            if (w_retire) begin
                r_upd_pc      <= r_pc[w_head_idx];
                r_upd_h       <= r_h[w_head_idx];
                r_upd_v       <= r_v[w_head_idx];
                r_upd_pred    <= r_pred[w_head_idx];
                r_upd_outcome <= r_outcome[w_head_idx];
                r_head        <= r_head + 1'b1;
            end

            if (w_mismatch) begin
                r_recover_h <= {r_h[io.resolve_tag][GHR_WIDTH-2:0], io.resolve_taken};
                r_tail      <= w_res_ptr + 1'b1;
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + 1'b1;
            end

            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_fire && (TAG_W'(i) == w_tail_idx)) begin
                    r_valid[i]    <= 1'b1;
                    r_resolved[i] <= 1'b0;
                    r_pred[i]     <= io.alloc_pred;
                end
                if (w_res_legal && (TAG_W'(i) == io.resolve_tag)) begin
                    r_resolved[i] <= 1'b1;
                    r_outcome[i]  <= io.resolve_taken;
                end
                if ((w_retire && (TAG_W'(i) == w_head_idx)) || w_flush[i]) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign io.alloc_ready = w_alloc_ready;
    assign io.alloc_tag   = w_tail_idx;
    assign io.count       = w_count;
    assign io.upd_valid   = r_upd_valid;
    assign io.upd_pc      = r_upd_pc;
    assign io.upd_h       = r_upd_h;
    assign io.upd_v       = r_upd_v;
    assign io.upd_pred    = r_upd_pred;
    assign io.upd_outcome = r_upd_outcome;
    assign io.mispredict  = r_mispredict;
    assign io.recover_h   = r_recover_h;

`ifdef FASTPATH_UPQ_CHECK_EN
    logic r_err;
    logic w_proto_err;

    assign w_proto_err = (io.resolve_valid && !w_res_legal) || (io.alloc_valid && !w_alloc_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_proto_err) begin
            r_err <= 1'b1;
        end
    end

    assign io.err = r_err;

    a_illegal_resolve: assert property (@(posedge clk) disable iff (!rst_n)
        !(io.resolve_valid && !w_res_legal));
    a_alloc_overrun: assert property (@(posedge clk) disable iff (!rst_n)
        !(io.alloc_valid && !w_alloc_ready));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_count <= PW'(DEPTH));
`else
    assign io.err = 1'b0;
`endif
endmodule

// File: tb/tb_fastpath_update_queue.sv
`timescale 1ns/1ps
module tb_fastpath_update_queue;
    localparam int DEPTH     = 16;
    localparam int PC_WIDTH  = 64;
    localparam int GHR_WIDTH = 32;
    localparam int IDX_WIDTH = 6;
    localparam int TAG_W     = 4;
    localparam int VW        = GHR_WIDTH * IDX_WIDTH;

    typedef struct {
        logic [TAG_W-1:0]     tag;
        logic [PC_WIDTH-1:0]  pc;
        logic [GHR_WIDTH-1:0] h;
        logic [VW-1:0]        v;
        bit                   pred;
        bit                   resolved;
        bit                   outcome;
    } ent_t;

    typedef struct {
        logic [PC_WIDTH-1:0]  pc;
        logic [GHR_WIDTH-1:0] h;
        logic [VW-1:0]        v;
        bit                   pred;
        bit                   outcome;
        int                   cyc;
    } upd_t;

    typedef struct {
        logic [GHR_WIDTH-1:0] h;
        int                   cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fastpath_update_queue_if #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .GHR_WIDTH(GHR_WIDTH),
                               .IDX_WIDTH(IDX_WIDTH), .TAG_W(TAG_W)) io();

    fastpath_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .GHR_WIDTH(GHR_WIDTH),
                            .IDX_WIDTH(IDX_WIDTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    ent_t             mq[$];
    upd_t             sb[$];
    rec_t             rq[$];
    logic [TAG_W-1:0] next_tag;
    bit               exp_err;
    int               n_checks = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    upd_t             mon_u;
    rec_t             mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [VW-1:0] rand_v();
        return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One cycle: drive inputs, check combinational outputs against the model, advance the model.
    task automatic step(input bit av, input logic [PC_WIDTH-1:0] pc, input logic [GHR_WIDTH-1:0] h,
                        input logic [VW-1:0] v, input bit pr,
                        input bit rv, input logic [TAG_W-1:0] rt, input bit rk);
        int   n;
        int   ri;
        bit   retire;
        bit   mis;
        bit   rdy;
        ent_t e;
        upd_t u;
        rec_t r;
        io.alloc_valid   = av;
        io.alloc_pc      = pc;
        io.alloc_h       = h;
        io.alloc_v       = v;
        io.alloc_pred    = pr;
        io.resolve_valid = rv;
        io.resolve_tag   = rt;
        io.resolve_taken = rk;

        n      = mq.size();
        retire = (n > 0) && mq[0].resolved;
        ri     = -1;
        if (rv) begin
            for (int i = 0; i < n; i++) begin
                if (mq[i].tag == rt && !mq[i].resolved) ri = i;
            end
        end
        mis = 1'b0;
        if (ri >= 0) mis = (rk != mq[ri].pred);
        rdy = (n < DEPTH) && !mis;

        #1;
        chk("alloc_ready", VW'(io.alloc_ready), VW'(rdy));
        chk("count", VW'(io.count), VW'(n));
        chk("alloc_tag", VW'(io.alloc_tag), VW'(next_tag));
`ifdef FASTPATH_UPQ_CHECK_EN
        chk("err", VW'(io.err), VW'(exp_err));
        if ((rv && ri < 0) || (av && !rdy)) exp_err = 1'b1;
`endif
        if (retire) begin
            u.pc = mq[0].pc; u.h = mq[0].h; u.v = mq[0].v;
            u.pred = mq[0].pred; u.outcome = mq[0].outcome; u.cyc = cyc + 1;
            sb.push_back(u);
        end
        if (ri >= 0) begin
            e = mq[ri];
            e.resolved = 1'b1;
            e.outcome  = rk;
            mq[ri] = e;
        end
        if (mis) begin
            r.h   = {mq[ri].h[GHR_WIDTH-2:0], rk};
            r.cyc = cyc + 1;
            rq.push_back(r);
            while (mq.size() > ri + 1) void'(mq.pop_back());
            next_tag = rt + 1'b1;
        end
        if (av && rdy) begin
            e.tag = next_tag; e.pc = pc; e.h = h; e.v = v;
            e.pred = pr; e.resolved = 1'b0; e.outcome = 1'b0;
            mq.push_back(e);
            next_tag = next_tag + 1'b1;
        end
        if (retire) void'(mq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic alloc(input logic [PC_WIDTH-1:0] pc, input logic [GHR_WIDTH-1:0] h, input bit pr);
        step(1'b1, pc, h, rand_v(), pr, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input logic [TAG_W-1:0] rt, input bit rk);
        step(1'b0, '0, '0, '0, 1'b0, 1'b1, rt, rk);
    endtask

    task automatic do_reset();
        io.alloc_valid = 1'b0; io.alloc_pc = '0; io.alloc_h = '0; io.alloc_v = '0; io.alloc_pred = 1'b0;
        io.resolve_valid = 1'b0; io.resolve_tag = '0; io.resolve_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_upd_valid", VW'(io.upd_valid), '0);
        chk("rst_upd_pc", VW'(io.upd_pc), '0);
        chk("rst_upd_h", VW'(io.upd_h), '0);
        chk("rst_upd_v", io.upd_v, '0);
        chk("rst_upd_pred", VW'(io.upd_pred), '0);
        chk("rst_upd_outcome", VW'(io.upd_outcome), '0);
        chk("rst_mispredict", VW'(io.mispredict), '0);
        chk("rst_recover_h", VW'(io.recover_h), '0);
        chk("rst_count", VW'(io.count), '0);
        chk("rst_alloc_tag", VW'(io.alloc_tag), '0);
        chk("rst_alloc_ready", VW'(io.alloc_ready), VW'(1));
        chk("rst_err", VW'(io.err), '0);
        mq.delete(); sb.delete(); rq.delete();
        next_tag = '0;
        exp_err  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: compares every update and recovery pulse the DUT presents.
    always @(negedge clk) begin
        if (rst_n) begin
            if (io.upd_valid) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL upd_unexpected: got upd_valid=1 pc=%0h expected no update (cycle %0d)", io.upd_pc, cyc);
                end else begin
                    mon_u = sb.pop_front();
                    chk("upd_cycle", VW'(cyc), VW'(mon_u.cyc));
                    chk("upd_pc", VW'(io.upd_pc), VW'(mon_u.pc));
                    chk("upd_h", VW'(io.upd_h), VW'(mon_u.h));
                    chk("upd_v", io.upd_v, mon_u.v);
                    chk("upd_pred", VW'(io.upd_pred), VW'(mon_u.pred));
                    chk("upd_outcome", VW'(io.upd_outcome), VW'(mon_u.outcome));
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_u = sb.pop_front();
                n_checks++; n_fail++;
                $display("FAIL upd_missing: got upd_valid=0 expected update pc=%0h (cycle %0d)", mon_u.pc, cyc);
            end
            if (io.mispredict) begin
                if (rq.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL mispredict_unexpected: got mispredict=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_r = rq.pop_front();
                    chk("mispredict_cycle", VW'(cyc), VW'(mon_r.cyc));
                    chk("recover_h", VW'(io.recover_h), VW'(mon_r.h));
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                mon_r = rq.pop_front();
                n_checks++; n_fail++;
                $display("FAIL mispredict_missing: got mispredict=0 expected recover_h=%0h (cycle %0d)", mon_r.h, cyc);
            end
        end
    end

    initial begin
        next_tag = '0;
        exp_err  = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Single correct prediction.
        alloc(64'h40, 32'h0000_0001, 1'b1);
        idle(1);
        resolve(4'd0, 1'b1);
        idle(4);

        // Out-of-order resolve, in-order retire.
        do_reset();
        for (int i = 0; i < 3; i++) alloc(64'h100 + 64'(i), $urandom(), 1'b1);
        resolve(4'd2, 1'b1);
        resolve(4'd1, 1'b1);
        resolve(4'd0, 1'b1);
        idle(5);

        // Mispredict on tag1 flushes tags 2,3.
        do_reset();
        alloc(64'h200, 32'h1234_5678, 1'b1);
        alloc(64'h204, 32'hAAAA_AAAA, 1'b0);
        alloc(64'h208, 32'h0F0F_0F0F, 1'b1);
        alloc(64'h20C, 32'hF0F0_F0F0, 1'b1);
        resolve(4'd1, 1'b1);
        resolve(4'd2, 1'b1);
        resolve(4'd3, 1'b1);
        alloc(64'h300, 32'h0000_00FF, 1'b0);
        resolve(4'd0, 1'b1);
        resolve(4'd2, 1'b0);
        idle(5);

        // Fill to DEPTH, overflow attempt, free one slot.
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(64'h1000 + 64'(i * 4), $urandom(), 1'(i & 1));
        alloc(64'hDEAD, 32'hDEAD, 1'b1);
        resolve(4'd0, 1'b0);
        idle(2);
        alloc(64'h2000, 32'h2000, 1'b1);
        for (int i = 1; i <= DEPTH; i++) begin
            resolve(TAG_W'(i), (i == DEPTH) ? 1'b1 : 1'(i & 1));
        end
        idle(4);

        // 40 entries streaming through, tags wrap.
        do_reset();
        for (int k = 0; k < 43; k++) begin
            step(k < 40, 64'h4000 + 64'(k), $urandom(), rand_v(), 1'(k & 1),
                 k >= 3, TAG_W'(k - 3), 1'((k - 3) & 1));
        end
        idle(4);

`ifdef FASTPATH_UPQ_CHECK_EN
        // Illegal resolve on an empty queue sets sticky err.
        resolve(4'd5, 1'b1);
        idle(3);
`endif

        // Random traffic with a mid-stream reset.
        for (int k = 0; k < 1500; k++) begin
            bit               av;
            bit               rv;
            bit               rk;
            logic [TAG_W-1:0] rt;
            int               idx;
            av = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 55);
            rt = TAG_W'($urandom_range(0, DEPTH - 1));
            rk = 1'($urandom_range(0, 1));
            if (rv && mq.size() > 0 && $urandom_range(0, 9) < 8) begin
                idx = $urandom_range(0, mq.size() - 1);
                rt  = mq[idx].tag;
                rk  = ($urandom_range(0, 9) < 8) ? mq[idx].pred : !mq[idx].pred;
            end
            step(av, {$urandom(), $urandom()}, $urandom(), rand_v(), 1'($urandom_range(0, 1)), rv, rt, rk);
            if (k == 700) do_reset();
        end

        // Drain: resolve whatever is left, correctly and in order.
        for (int k = 0; k < 3 * DEPTH && mq.size() > 0; k++) begin
            int ui;
            ui = -1;
            for (int i = mq.size() - 1; i >= 0; i--) if (!mq[i].resolved) ui = i;
            if (ui >= 0) resolve(mq[ui].tag, mq[ui].pred);
            else idle(1);
        end
        idle(5);
        chk("final_count", VW'(io.count), '0);
        chk("final_sb_empty", VW'(sb.size()), '0);
        chk("final_rq_empty", VW'(rq.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
